// File: rtl/onchip_memory_port_arbiter.sv
// Two-master arbiter for one port of the on-chip memory.
// m0 (processor data master) and m1 (DMA/video master) share a single 32-bit
// memory port. Arbitration is round-robin with a bounded hold, so one master
// can stream back-to-back beats without starving the other. Read data is
// routed back to the master that issued the read after READ_LATENCY clocks.
//
// Handshake: a master requests a beat by raising mN_read and/or mN_write and
// holds the request, address and data stable while mN_waitrequest is high.
// A beat is accepted in the cycle where the request is high and
// mN_waitrequest is low; the memory sees it on that same clock edge. When
// read and write are both high, the beat is a write.
module onchip_memory_port_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 32,
    parameter int BE_W         = 4,
    parameter int READ_LATENCY = 1,
    parameter int MAX_HOLD     = 4,
    localparam int HOLD_W      = $clog2(MAX_HOLD + 1)
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,

    // Debug view of the arbiter state
    output logic [1:0]        dbg_state,
    output logic [HOLD_W-1:0] dbg_hold_cnt,
    output logic              dbg_last_grant
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SERVE0 = 2'd1,
        ST_SERVE1 = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                last_grant_q, last_grant_d;
    logic [READ_LATENCY-1:0] rd_vld_q, rd_vld_d;
    logic [READ_LATENCY-1:0] rd_own_q, rd_own_d;

    logic              req0, req1;
    logic              gnt0_raw, gnt1_raw;
    logic              grant0, grant1;
    logic              issue, issue_wr, issue_rd;
    logic              hold_full;
    logic [HOLD_W-1:0] hold_next;
    logic              tap_vld, tap_own;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Hold counter saturates at MAX_HOLD while one master streams uncontested.
    assign hold_full = (hold_cnt_q >= HOLD_W'(MAX_HOLD));
    assign hold_next = hold_full ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);

    // Next-state and raw grant: round-robin on ties, bounded hold while contested.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        gnt0_raw   = 1'b0;
        gnt1_raw   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // On a tie the master that did not issue last wins.
                if (req0 && (!req1 || last_grant_q)) begin
                    gnt0_raw   = 1'b1;
                    state_d    = ST_SERVE0;
                    hold_cnt_d = HOLD_W'(1);
                end else if (req1) begin
                    gnt1_raw   = 1'b1;
                    state_d    = ST_SERVE1;
                    hold_cnt_d = HOLD_W'(1);
                end
            end
            ST_SERVE0: begin
                if (req0 && (!hold_full || !req1)) begin
                    gnt0_raw   = 1'b1;
                    hold_cnt_d = hold_next;
                end else if (req1) begin
                    gnt1_raw   = 1'b1;
                    state_d    = ST_SERVE1;
                    hold_cnt_d = HOLD_W'(1);
                end else begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                end
            end
            ST_SERVE1: begin
                if (req1 && (!hold_full || !req0)) begin
                    gnt1_raw   = 1'b1;
                    hold_cnt_d = hold_next;
                end else if (req0) begin
                    gnt0_raw   = 1'b1;
                    state_d    = ST_SERVE0;
                    hold_cnt_d = HOLD_W'(1);
                end else begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

    // No beat may reach the memory while reset is asserted, even though the
    // registered state already reads IDLE.
    assign grant0 = gnt0_raw & ~reset;
    assign grant1 = gnt1_raw & ~reset;

    assign m0_waitrequest = req0 & ~grant0;
    assign m1_waitrequest = req1 & ~grant1;

    assign issue    = grant0 | grant1;
    assign issue_wr = grant0 ? m0_write : (grant1 ? m1_write : 1'b0);
    assign issue_rd = issue & ~issue_wr;

    // Track which master issued last; drives the tie-break in IDLE.
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant1) begin
            last_grant_d = 1'b1;
        end else if (grant0) begin
            last_grant_d = 1'b0;
        end
    end

    // Memory-side mux: everything is zero in cycles with no beat.
    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        mem_chipselect = issue;
        mem_write      = issue & issue_wr;
        if (grant0) begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_writedata  = m0_writedata;
        end else if (grant1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
        end
    end

    assign mem_clken = 1'b1;

    // Read tag pipe: each issued read carries its owner to the data tap.
    always_comb begin
        rd_vld_d    = rd_vld_q;
        rd_own_d    = rd_own_q;
        rd_vld_d[0] = issue_rd;
        rd_own_d[0] = grant1;
        for (int i = 1; i < READ_LATENCY; i++) begin
            rd_vld_d[i] = rd_vld_q[i-1];
            rd_own_d[i] = rd_own_q[i-1];
        end
    end

    assign tap_vld = rd_vld_q[READ_LATENCY-1];
    assign tap_own = rd_own_q[READ_LATENCY-1];

    assign m0_readdatavalid = tap_vld & ~tap_own;
    assign m1_readdatavalid = tap_vld &  tap_own;

    // Read data is broadcast; readdatavalid alone says whose it is.
    assign m0_readdata = reset ? '0 : mem_readdata;
    assign m1_readdata = reset ? '0 : mem_readdata;

    // State registers; reset also drops any reads still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            hold_cnt_q   <= '0;
            last_grant_q <= 1'b1;
            rd_vld_q     <= '0;
            rd_own_q     <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            last_grant_q <= last_grant_d;
            rd_vld_q     <= rd_vld_d;
            rd_own_q     <= rd_own_d;
        end
    end

    assign dbg_state      = state_q;
    assign dbg_hold_cnt   = hold_cnt_q;
    assign dbg_last_grant = last_grant_q;

endmodule

// File: tb/tb_onchip_memory_port_arbiter.sv
// Bench for onchip_memory_port_arbiter: per-cycle vector table for grant and
// timing behaviour, a shadow-memory scoreboard for read data, a few hand
// checks for the multi-cycle corner cases, and a short random phase.
module tb_onchip_memory_port_arbiter;

    localparam logic [1:0] C_NONE = 2'd0;
    localparam logic [1:0] C_RD   = 2'd1;
    localparam logic [1:0] C_WR   = 2'd2;
    localparam logic [1:0] C_RW   = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic [10:0] m0_address, m1_address, mem_address;
    logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, mem_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata, mem_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [1:0]  dbg_state;
    logic [2:0]  dbg_hold_cnt;
    logic        dbg_last_grant;

    onchip_memory_port_arbiter dut (
        .clk              (clk),
        .reset            (rst),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata),
        .dbg_state        (dbg_state),
        .dbg_hold_cnt     (dbg_hold_cnt),
        .dbg_last_grant   (dbg_last_grant)
    );

    // ---------------- memory model (address-registered, latency 1) ----------------
    function automatic logic [31:0] pre(input logic [10:0] a);
        return {16'hC0DE, 5'b0, a};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    logic [31:0] ram [2048];
    bit   [2047:0] ram_wr;
    logic [31:0] ram_q;

    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                ram[mem_address]    <= merge(ram_wr[mem_address] ? ram[mem_address] : pre(mem_address),
                                             mem_writedata, mem_byteenable);
                ram_wr[mem_address] <= 1'b1;
            end else begin
                ram_q <= ram_wr[mem_address] ? ram[mem_address] : pre(mem_address);
            end
        end
    end
    assign mem_readdata = ram_q;

    // ---------------- checking ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;
    int cnt_v0    = 0;
    int cnt_v1    = 0;
    logic [31:0] last_rd0, last_rd1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endfunction

    function automatic void check1(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endfunction

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    logic [31:0] sh [2048];
    bit   [2047:0] sh_wr;

    function automatic logic [31:0] sh_get(input logic [10:0] a);
        return sh_wr[a] ? sh[a] : pre(a);
    endfunction

    function automatic void sb_beat(input logic owner, input logic wr, input logic [10:0] a,
                                    input logic [3:0] be, input logic [31:0] d);
        if (wr) begin
            sh[a]    = merge(sh_get(a), d, be);
            sh_wr[a] = 1'b1;
        end else if (owner) begin
            exp_q1.push_back(sh_get(a));
        end else begin
            exp_q0.push_back(sh_get(a));
        end
    endfunction

    // Monitor: pop/compare returning reads, then record accepted beats.
    always @(negedge clk) begin
        logic acc0, acc1;
        if (rst) begin
            check("rdv_during_reset", {30'b0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            if (m0_readdatavalid) begin
                cnt_v0++;
                last_rd0 = m0_readdata;
                if (exp_q0.size() == 0) check1("m0_unexpected_rdv", 1'b1, 1'b0);
                else check("m0_readdata", m0_readdata, exp_q0.pop_front());
            end
            if (m1_readdatavalid) begin
                cnt_v1++;
                last_rd1 = m1_readdata;
                if (exp_q1.size() == 0) check1("m1_unexpected_rdv", 1'b1, 1'b0);
                else check("m1_readdata", m1_readdata, exp_q1.pop_front());
            end
            acc0 = (m0_read | m0_write) & ~m0_waitrequest;
            acc1 = (m1_read | m1_write) & ~m1_waitrequest;
            check("one_beat_cs", {30'b0, acc0 & acc1, mem_chipselect}, {30'b0, 1'b0, acc0 | acc1});
            if (acc0) sb_beat(1'b0, m0_write, m0_address, m0_byteenable, m0_writedata);
            if (acc1) sb_beat(1'b1, m1_write, m1_address, m1_byteenable, m1_writedata);
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic [1:0]  c0, c1;
        logic [10:0] a0, a1;
        logic [3:0]  be0, be1;
        logic [31:0] d0, d1;
        logic        ew0, ew1, ecs, ewr;
        logic [10:0] eaddr;
        logic        ev0, ev1;
        logic        chk_hold;
        logic [2:0]  ehold;
    } vec_t;

    vec_t vecs[64];
    int   nv = 0;

    task automatic add(input int r, input logic [1:0] c0, input int a0, input logic [1:0] c1,
                       input int a1, input int ew0, input int ew1, input int ecs, input int ewr,
                       input int eaddr, input int ev0, input int ev1);
        vec_t v;
        v.rst      = (r != 0);
        v.c0       = c0;
        v.c1       = c1;
        v.a0       = 11'(a0);
        v.a1       = 11'(a1);
        v.be0      = 4'hF;
        v.be1      = 4'hF;
        v.d0       = {16'hA000, 5'b0, 11'(a0)};
        v.d1       = {16'hB000, 5'b0, 11'(a1)};
        v.ew0      = (ew0 != 0);
        v.ew1      = (ew1 != 0);
        v.ecs      = (ecs != 0);
        v.ewr      = (ewr != 0);
        v.eaddr    = 11'(eaddr);
        v.ev0      = (ev0 != 0);
        v.ev1      = (ev1 != 0);
        v.chk_hold = 1'b0;
        v.ehold    = 3'd0;
        vecs[nv]   = v;
        nv++;
    endtask

    task automatic set_hold(input int h);
        vecs[nv-1].chk_hold = 1'b1;
        vecs[nv-1].ehold    = 3'(h);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input vec_t v);
        rst           = v.rst;
        m0_read       = v.c0[0];
        m0_write      = v.c0[1];
        m0_address    = v.a0;
        m0_byteenable = v.be0;
        m0_writedata  = v.d0;
        m1_read       = v.c1[0];
        m1_write      = v.c1[1];
        m1_address    = v.a1;
        m1_byteenable = v.be1;
        m1_writedata  = v.d1;
    endtask

    task automatic run_vecs(input int from, input int to);
        for (int i = from; i < to; i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            @(negedge clk);
            check1($sformatf("v%0d_m0_wait", i), m0_waitrequest, vecs[i].ew0);
            check1($sformatf("v%0d_m1_wait", i), m1_waitrequest, vecs[i].ew1);
            check1($sformatf("v%0d_mem_cs", i), mem_chipselect, vecs[i].ecs);
            check1($sformatf("v%0d_mem_wr", i), mem_write, vecs[i].ewr);
            check($sformatf("v%0d_mem_addr", i), {21'b0, mem_address}, {21'b0, vecs[i].eaddr});
            check1($sformatf("v%0d_m0_rdv", i), m0_readdatavalid, vecs[i].ev0);
            check1($sformatf("v%0d_m1_rdv", i), m1_readdatavalid, vecs[i].ev1);
            if (vecs[i].chk_hold)
                check($sformatf("v%0d_hold", i), {29'b0, dbg_hold_cnt}, {29'b0, vecs[i].ehold});
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int seg_a, seg_b, seg_c, base_v0;
        logic [1:0] rc0, rc1;

        rst = 1'b1;
        m0_read = 1'b1; m0_write = 1'b0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
        m1_read = 1'b0; m1_write = 1'b1; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;

        // Test 1: simultaneous reads after reset
        add(0, C_RD,   'h010, C_RD,   'h020, 0, 1, 1, 0, 'h010, 0, 0);
        add(0, C_NONE, 0,     C_RD,   'h020, 0, 0, 1, 0, 'h020, 1, 0);
        add(0, C_NONE, 0,     C_NONE, 0,     0, 0, 0, 0, 0,     0, 1);
        // Test 2: m0 eight writes vs m1 continuous reads -> m0 x4, m1 x4, m0 x4
        for (int i = 0; i < 4; i++) begin
            add(0, C_WR, 'h100 + i, C_RD, 'h200, 0, 1, 1, 1, 'h100 + i, 0, 0);
            set_hold(i);
        end
        for (int j = 0; j < 4; j++) begin
            add(0, C_WR, 'h104, C_RD, 'h200 + j, 1, 0, 1, 0, 'h200 + j, 0, (j > 0) ? 1 : 0);
            set_hold((j == 0) ? 4 : j);
        end
        for (int i = 4; i < 8; i++) begin
            add(0, C_WR, 'h100 + i, C_RD, 'h204, 0, 1, 1, 1, 'h100 + i, 0, (i == 4) ? 1 : 0);
            set_hold((i == 4) ? 4 : i - 4);
        end
        add(0, C_NONE, 0, C_RD,   'h204, 0, 0, 1, 0, 'h204, 0, 0);
        set_hold(4);
        add(0, C_NONE, 0, C_NONE, 0,     0, 0, 0, 0, 0,     0, 1);
        // Test 3: partial write at top address, then read back by m1
        add(0, C_WR, 'h7FF, C_NONE, 0, 0, 0, 1, 1, 'h7FF, 0, 0);
        vecs[nv-1].be0 = 4'b0011;
        vecs[nv-1].d0  = 32'hDEADBEEF;
        add(0, C_NONE, 0, C_RD,   'h7FF, 0, 0, 1, 0, 'h7FF, 0, 0);
        add(0, C_NONE, 0, C_NONE, 0,     0, 0, 0, 0, 0,     0, 1);
        seg_a = nv;
        // Test 4: uncontested stream of 10 reads, hold saturates at 4
        for (int k = 0; k < 10; k++) begin
            add(0, C_RD, 'h300 + k, C_NONE, 0, 0, 0, 1, 0, 'h300 + k, (k > 0) ? 1 : 0, 0);
            set_hold((k < 4) ? k : 4);
        end
        add(0, C_NONE, 0, C_NONE, 0, 0, 0, 0, 0, 0, 1, 0);
        seg_b = nv;
        // Test 5: reset with a read in flight; next tie goes to m0
        add(0, C_RD,   'h050, C_NONE, 0,     0, 0, 1, 0, 'h050, 0, 0);
        add(1, C_NONE, 0,     C_RD,   'h060, 0, 1, 0, 0, 0,     0, 0);
        set_hold(0);
        add(0, C_RD,   'h070, C_RD,   'h060, 0, 1, 1, 0, 'h070, 0, 0);
        add(0, C_NONE, 0,     C_RD,   'h060, 0, 0, 1, 0, 'h060, 1, 0);
        add(0, C_NONE, 0,     C_NONE, 0,     0, 0, 0, 0, 0,     0, 1);
        // Test 6: m1 read+write together is a write with no response
        add(0, C_NONE, 0,     C_RW,   'h005, 0, 0, 1, 1, 'h005, 0, 0);
        add(0, C_NONE, 0,     C_NONE, 0,     0, 0, 0, 0, 0,     0, 0);
        add(0, C_RD,   'h005, C_NONE, 0,     0, 0, 1, 0, 'h005, 0, 0);
        add(0, C_NONE, 0,     C_NONE, 0,     0, 0, 0, 0, 0,     1, 0);
        seg_c = nv;

        // Reset state, with requests present during reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", {30'b0, dbg_state}, 32'd0);
        check("rst_hold", {29'b0, dbg_hold_cnt}, 32'd0);
        check1("rst_last_grant", dbg_last_grant, 1'b1);
        check1("rst_m0_wait", m0_waitrequest, 1'b1);
        check1("rst_m1_wait", m1_waitrequest, 1'b1);
        check1("rst_mem_cs", mem_chipselect, 1'b0);
        check1("rst_mem_wr", mem_write, 1'b0);
        check1("rst_mem_clken", mem_clken, 1'b1);
        check("rst_m0_readdata", m0_readdata, 32'd0);

        run_vecs(0, seg_a);
        @(posedge clk);
        check("t3_m1_readback", last_rd1, 32'hC0DEBEEF);

        base_v0 = cnt_v0;
        run_vecs(seg_a, seg_b);
        @(posedge clk);
        check("t4_rdv_pulses", cnt_v0 - base_v0, 32'd10);

        run_vecs(seg_b, seg_c);
        @(posedge clk);
        check("t6_m0_readback", last_rd0, 32'hB0000005);

        // Random traffic on a small address window; scoreboard checks data
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #1;
            rc0 = 2'($urandom_range(0, 3));
            rc1 = 2'($urandom_range(0, 3));
            m0_read       = rc0[0];
            m0_write      = rc0[1];
            m0_address    = 11'('h400 + $urandom_range(0, 7));
            m0_byteenable = 4'($urandom_range(1, 15));
            m0_writedata  = $urandom;
            m1_read       = rc1[0];
            m1_write      = rc1[1];
            m1_address    = 11'('h400 + $urandom_range(0, 7));
            m1_byteenable = 4'($urandom_range(1, 15));
            m1_writedata  = $urandom;
        end
        @(posedge clk);
        #1;
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
        repeat (3) @(posedge clk);
        check("q0_drained", exp_q0.size(), 32'd0);
        check("q1_drained", exp_q1.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
